// File: rtl/cv32e41s_pkg.sv
// Shared types for the cv32e41s request-side PMR filter.
//   pmp_req_e          : access type presented to the PMP lookup
//   pmr_filter_state_e : control states of cv32e41s_pmr_req_filter
//   pmr_reloc_fault()  : combines the PMP verdict with relocation range checking
package cv32e41s_pkg;

  typedef enum logic [1:0] {
    PMP_ACC_READ  = 2'b00,
    PMP_ACC_WRITE = 2'b01,
    PMP_ACC_EXEC  = 2'b10
  } pmp_req_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    BUS_REQ  = 2'b01,
    ERR_WAIT = 2'b10,
    ERR_RESP = 2'b11
  } pmr_filter_state_e;

  // A relocated address that lands outside the 32-bit space (overflow or
  // underflow shows up in the two guard bits) is as bad as a PMP denial.
  function automatic logic pmr_reloc_fault(input logic        pmp_err,
                                           input logic [33:0] reloc_addr);
    return pmp_err || (reloc_addr[33:32] != 2'b00);
  endfunction

endpackage

// File: rtl/cv32e41s_pmr_outstanding_cnt.sv
// Up/down counter of bus transactions granted but not yet responded.
//   clk, rst : clock, synchronous active-high reset (count returns to 0)
//   inc_i    : a bus request was granted this cycle
//   dec_i    : a bus response arrived this cycle
//   full_o   : count == MAX_OUTSTANDING, no further request may be issued
//   empty_o  : count == 0
// The count saturates at both ends; a response with nothing outstanding is a
// bus protocol violation and is flagged by an assertion.
module cv32e41s_pmr_outstanding_cnt #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign full_o  = (cnt_q == MAX_CNT);
  assign empty_o = (cnt_q == '0);

  // Increment and decrement are applied independently so that a grant and a
  // response in the same cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !full_o) begin
      cnt_d = cnt_d + CNT_W'(1);
    end
    if (dec_i && !empty_o) begin
      cnt_d = cnt_d - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(dec_i && empty_o));
      assert (!(inc_i && full_o));
    end
  end

endmodule

// File: rtl/cv32e41s_pmr_req_filter.sv
// Request-side filter between a core master and the OBI bus, directly
// downstream of the PMP.
//   core_*     : OBI-like core request (req/gnt) and response (rvalid/rdata/err)
//   pmp_*      : combinational PMP lookup driven from the incoming request;
//                verdict and relocated address come back the same cycle
//   bus_*      : OBI master towards the bus, address taken from the relocation
// A granted core request is captured into a holding register. Permitted
// requests are issued on the bus; faulting ones never reach the bus and get a
// synthetic error response once all earlier bus responses have drained.
import cv32e41s_pkg::*;

module cv32e41s_pmr_req_filter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        core_req_i,
  output logic        core_gnt_o,
  input  logic [31:0] core_addr_i,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_wdata_i,
  input  logic        core_instr_i,
  input  logic        core_debug_region_i,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,

  output logic [33:0] pmp_req_addr_o,
  output pmp_req_e    pmp_req_type_o,
  output logic        pmp_req_debug_region_o,
  input  logic [33:0] pmp_reloc_addr_i,
  input  logic        pmp_err_i,

  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
);

  pmr_filter_state_e state_q, state_d;

  logic [31:0] addr_q,  addr_d;
  logic        we_q,    we_d;
  logic [3:0]  be_q,    be_d;
  logic [31:0] wdata_q, wdata_d;

  logic     core_gnt;
  logic     bus_req;
  logic     err_resp;
  logic     capture;
  logic     cap_err;
  logic     bus_fire;
  logic     cnt_full;
  logic     cnt_empty;
  pmp_req_e req_type;

  assign req_type = core_instr_i ? PMP_ACC_EXEC  :
                    core_we_i    ? PMP_ACC_WRITE : PMP_ACC_READ;

  assign cap_err  = pmr_reloc_fault(pmp_err_i, pmp_reloc_addr_i);
  assign bus_fire = bus_req && bus_gnt_i;

  cv32e41s_pmr_outstanding_cnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_outstanding_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (bus_fire),
    .dec_i   (bus_rvalid_i),
    .full_o  (cnt_full),
    .empty_o (cnt_empty)
  );

  always_comb begin
    state_d  = state_q;
    core_gnt = 1'b0;
    bus_req  = 1'b0;
    err_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        core_gnt = 1'b1;
        if (core_req_i) begin
          state_d = cap_err ? ERR_WAIT : BUS_REQ;
        end
      end
      BUS_REQ: begin
        bus_req = !cnt_full;
        // The holding register frees up on the grant, so a new request can
        // be accepted in the same cycle.
        if (bus_req && bus_gnt_i) begin
          core_gnt = 1'b1;
          if (core_req_i) begin
            state_d = cap_err ? ERR_WAIT : BUS_REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      ERR_WAIT: begin
        // Hold the error until every earlier bus response has been returned
        // so responses reach the core in issue order.
        if (cnt_empty && !bus_rvalid_i) begin
          state_d = ERR_RESP;
        end
      end
      ERR_RESP: begin
        err_resp = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    capture = core_req_i && core_gnt;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    if (capture) begin
      addr_d  = pmp_reloc_addr_i[31:0];
      we_d    = core_we_i;
      be_d    = core_be_i;
      wdata_d = core_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  // Every output is forced low while reset is held, including the
  // combinational pass-through paths.
  assign core_gnt_o             = !rst && core_gnt;
  assign bus_req_o              = !rst && bus_req;
  assign bus_addr_o             = rst ? '0 : addr_q;
  assign bus_we_o               = !rst && we_q;
  assign bus_be_o               = rst ? '0 : be_q;
  assign bus_wdata_o            = rst ? '0 : wdata_q;

  assign pmp_req_addr_o         = rst ? '0 : {2'b00, core_addr_i};
  assign pmp_req_type_o         = rst ? PMP_ACC_READ : req_type;
  assign pmp_req_debug_region_o = !rst && core_debug_region_i;

  assign core_rvalid_o          = !rst && (err_resp || bus_rvalid_i);
  assign core_err_o             = !rst && (err_resp || bus_err_i);
  assign core_rdata_o           = (rst || err_resp) ? '0 : bus_rdata_i;

endmodule
